// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

   // Default register-address width of the 5-stage pipeline.
   localparam int REG_AW_DEF = 5;

   // Architectural zero register: never a real producer/consumer.
   localparam int ZERO_REG = 0;

   // Hazard FSM: normal issue, or squashing IF/ID after a control op.
   typedef enum logic {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Operand/producer info in, per-boundary stall/flush strobes and perf counters out.
// Latency: strobes combinational, counters registered.
// Backpressure: MemBusy_IN is the only backpressure; it freezes the front of the pipe.
interface pipeline_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = 16
);
   logic              Jump_IN;
   logic              Branch_IN;
   logic [REG_AW-1:0] IDRegisterRS_IN;
   logic [REG_AW-1:0] IDRegisterRT_IN;
   logic              IDUsesRS_IN;
   logic              IDUsesRT_IN;
   logic [REG_AW-1:0] IDEXEWriteRegister_IN;
   logic              IDEXEWriteEnable_IN;
   logic              IDEXEMemRead_IN;
   logic [REG_AW-1:0] EXEMEMWriteRegister_IN;
   logic              EXEMEMMemRead_IN;
   logic              MemBusy_IN;
   logic              ClearCount_IN;

   logic              STALL_IFID;
   logic              FLUSH_IFID;
   logic              STALL_IDEXE;
   logic              FLUSH_IDEXE;
   logic              STALL_EXEMEM;
   logic              FLUSH_EXEMEM;
   logic              STALL_MEMWB;
   logic              FLUSH_MEMWB;
   logic [CNT_W-1:0]  STALL_COUNT_OUT;
   logic [CNT_W-1:0]  BUBBLE_COUNT_OUT;

   // Pipeline side: supplies operand info, consumes strobes.
   modport master (
      output Jump_IN, Branch_IN, IDRegisterRS_IN, IDRegisterRT_IN, IDUsesRS_IN, IDUsesRT_IN,
             IDEXEWriteRegister_IN, IDEXEWriteEnable_IN, IDEXEMemRead_IN,
             EXEMEMWriteRegister_IN, EXEMEMMemRead_IN, MemBusy_IN, ClearCount_IN,
      input  STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM, FLUSH_EXEMEM,
             STALL_MEMWB, FLUSH_MEMWB, STALL_COUNT_OUT, BUBBLE_COUNT_OUT
   );

   // Hazard unit side.
   modport slave (
      input  Jump_IN, Branch_IN, IDRegisterRS_IN, IDRegisterRT_IN, IDUsesRS_IN, IDUsesRT_IN,
             IDEXEWriteRegister_IN, IDEXEWriteEnable_IN, IDEXEMemRead_IN,
             EXEMEMWriteRegister_IN, EXEMEMMemRead_IN, MemBusy_IN, ClearCount_IN,
      output STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM, FLUSH_EXEMEM,
             STALL_MEMWB, FLUSH_MEMWB, STALL_COUNT_OUT, BUBBLE_COUNT_OUT
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: 1 cycle from inc to count.
// Backpressure: none; holds at all-ones instead of wrapping.
module hazard_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   // Count events, stick at all-ones, clear on request.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection and per-boundary stall/flush generation for the IF/ID/EXE/MEM/WB pipe.
// Latency: strobes are combinational (0 cycles); ring, FSM and counters update on CLOCK.
// Backpressure: MemBusy_IN freezes IF..EXE, bubbles MEM/WB and freezes ring and FSM.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW     = REG_AW_DEF,
   parameter int RING_LEN   = 5,
   parameter int BR_PENALTY = 0,
   parameter int CNT_W      = 16
) (
   input logic                   CLOCK,
   input logic                   RESET,
   pipeline_hazard_ctrl_if.slave hz
);

   // A source depends on a producer only if it is really read and is not r0.
   function automatic logic src_match(input logic uses, input logic [REG_AW-1:0] src,
                                      input logic [REG_AW-1:0] dst);
      return uses && (int'(src) != ZERO_REG) && (src == dst);
   endfunction

   logic ctrl_op, busy;
   logic x_rs, x_rt, m_rs, m_rt;
   logic lu, bd, dh;

   assign busy    = hz.MemBusy_IN;
   assign ctrl_op = hz.Jump_IN | hz.Branch_IN;
   assign x_rs    = src_match(hz.IDUsesRS_IN, hz.IDRegisterRS_IN, hz.IDEXEWriteRegister_IN);
   assign x_rt    = src_match(hz.IDUsesRT_IN, hz.IDRegisterRT_IN, hz.IDEXEWriteRegister_IN);
   assign m_rs    = src_match(hz.IDUsesRS_IN, hz.IDRegisterRS_IN, hz.EXEMEMWriteRegister_IN);
   assign m_rt    = src_match(hz.IDUsesRT_IN, hz.IDRegisterRT_IN, hz.EXEMEMWriteRegister_IN);

   // Load-use needs the load result in EXE; branches resolve in ID so they also wait on
   // ALU results in EXE and loads still in MEM. Re-evaluated every cycle, so a load
   // feeding a branch yields two bubbles with no extra state.
   assign lu = hz.IDEXEWriteEnable_IN & hz.IDEXEMemRead_IN & (x_rs | x_rt);
   assign bd = ctrl_op & ((hz.IDEXEWriteEnable_IN & (x_rs | x_rt)) |
                          (hz.EXEMEMMemRead_IN & (m_rs | m_rt)));
   assign dh = lu | bd;

   // ---------------- issue ring ----------------
   logic [RING_LEN-1:0] ring_q;
   logic                ring_gap;

   // Rotate the one-hot issue slot; hold it during memory stalls to keep the gap phase.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         ring_q <= RING_LEN'(1);
      end else if (!busy) begin
         ring_q <= (ring_q << 1) | (ring_q >> (RING_LEN - 1));
      end
   end

   assign ring_gap = (RING_LEN > 1) ? ~ring_q[0] : 1'b0;

   // ---------------- squash FSM ----------------
   hz_state_t  state_q, state_d;
   logic [1:0] pen_q, pen_d;

   // State register and penalty counter.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q <= RUN;
         pen_q   <= '0;
      end else begin
         state_q <= state_d;
         pen_q   <= pen_d;
      end
   end

   // Next state: enter SQUASH when a clean control op leaves ID; count down on non-busy cycles.
   always_comb begin
      state_d = state_q;
      pen_d   = pen_q;
      if (!busy) begin
         case (state_q)
            RUN: begin
               if (ctrl_op && !dh && (BR_PENALTY > 0)) begin
                  state_d = SQUASH;
                  pen_d   = 2'(BR_PENALTY);
               end
            end
            SQUASH: begin
               if (pen_q <= 2'd1) begin
                  state_d = RUN;
                  pen_d   = '0;
               end else begin
                  pen_d = pen_q - 2'd1;
               end
            end
            default: begin
               state_d = RUN;
               pen_d   = '0;
            end
         endcase
      end
   end

   // ---------------- strobes ----------------
   logic stall_ifid, flush_ifid, stall_idexe, flush_idexe, stall_exemem, flush_memwb;

   // Output decode in priority order: memory busy, data hazard, squash, ring gap.
   always_comb begin
      stall_ifid   = 1'b0;
      flush_ifid   = 1'b0;
      stall_idexe  = 1'b0;
      flush_idexe  = 1'b0;
      stall_exemem = 1'b0;
      flush_memwb  = 1'b0;
      if (RESET) begin
         stall_ifid = 1'b0;
      end else if (busy) begin
         stall_ifid   = 1'b1;
         stall_idexe  = 1'b1;
         stall_exemem = 1'b1;
         flush_memwb  = 1'b1;
      end else if (dh) begin
         stall_ifid  = 1'b1;
         flush_idexe = 1'b1;
      end else if (state_q == SQUASH) begin
         flush_ifid = 1'b1;
      end else if (ring_gap) begin
         stall_ifid = 1'b1;
         flush_ifid = 1'b1;
      end
   end

   assign hz.STALL_IFID   = stall_ifid;
   assign hz.FLUSH_IFID   = flush_ifid;
   assign hz.STALL_IDEXE  = stall_idexe;
   assign hz.FLUSH_IDEXE  = flush_idexe;
   assign hz.STALL_EXEMEM = stall_exemem;
   assign hz.FLUSH_EXEMEM = 1'b0;
   assign hz.STALL_MEMWB  = 1'b0;
   assign hz.FLUSH_MEMWB  = flush_memwb;

   // ---------------- performance counters ----------------
   logic [CNT_W-1:0] stall_cnt, bubble_cnt;

   hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .inc   (stall_ifid),
      .clr   (hz.ClearCount_IN),
      .count (stall_cnt)
   );

   hazard_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .inc   (flush_idexe),
      .clr   (hz.ClearCount_IN),
      .count (bubble_cnt)
   );

   assign hz.STALL_COUNT_OUT  = stall_cnt;
   assign hz.BUBBLE_COUNT_OUT = bubble_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench: two configurations of the hazard unit driven by the same directed + random stimulus.
// Latency: outputs compared each cycle against a cycle-level reference model.
// Backpressure: MemBusy randomised alongside hazards.
module tb_pipeline_hazard_ctrl;

   logic       clk, rst;
   logic       jmp, br, urs, urt, xwe, xmr, mmr, busy, clr;
   logic [4:0] rs, rt, xw, mw;

   int n_chk = 0;
   int n_err = 0;

   pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if_a ();
   pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  if_b ();

   pipeline_hazard_ctrl #(.REG_AW(5), .RING_LEN(1), .BR_PENALTY(2), .CNT_W(16)) u_a (
      .CLOCK (clk),
      .RESET (rst),
      .hz    (if_a.slave)
   );

   pipeline_hazard_ctrl #(.REG_AW(5), .RING_LEN(5), .BR_PENALTY(3), .CNT_W(4)) u_b (
      .CLOCK (clk),
      .RESET (rst),
      .hz    (if_b.slave)
   );

   assign if_a.Jump_IN = jmp;                assign if_b.Jump_IN = jmp;
   assign if_a.Branch_IN = br;               assign if_b.Branch_IN = br;
   assign if_a.IDRegisterRS_IN = rs;         assign if_b.IDRegisterRS_IN = rs;
   assign if_a.IDRegisterRT_IN = rt;         assign if_b.IDRegisterRT_IN = rt;
   assign if_a.IDUsesRS_IN = urs;            assign if_b.IDUsesRS_IN = urs;
   assign if_a.IDUsesRT_IN = urt;            assign if_b.IDUsesRT_IN = urt;
   assign if_a.IDEXEWriteRegister_IN = xw;   assign if_b.IDEXEWriteRegister_IN = xw;
   assign if_a.IDEXEWriteEnable_IN = xwe;    assign if_b.IDEXEWriteEnable_IN = xwe;
   assign if_a.IDEXEMemRead_IN = xmr;        assign if_b.IDEXEMemRead_IN = xmr;
   assign if_a.EXEMEMWriteRegister_IN = mw;  assign if_b.EXEMEMWriteRegister_IN = mw;
   assign if_a.EXEMEMMemRead_IN = mmr;       assign if_b.EXEMEMMemRead_IN = mmr;
   assign if_a.MemBusy_IN = busy;            assign if_b.MemBusy_IN = busy;
   assign if_a.ClearCount_IN = clr;          assign if_b.ClearCount_IN = clr;

   // {STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM, FLUSH_EXEMEM, STALL_MEMWB, FLUSH_MEMWB}
   logic [7:0] out_a, out_b;
   assign out_a = {if_a.STALL_IFID, if_a.FLUSH_IFID, if_a.STALL_IDEXE, if_a.FLUSH_IDEXE,
                   if_a.STALL_EXEMEM, if_a.FLUSH_EXEMEM, if_a.STALL_MEMWB, if_a.FLUSH_MEMWB};
   assign out_b = {if_b.STALL_IFID, if_b.FLUSH_IFID, if_b.STALL_IDEXE, if_b.FLUSH_IDEXE,
                   if_b.STALL_EXEMEM, if_b.FLUSH_EXEMEM, if_b.STALL_MEMWB, if_b.FLUSH_MEMWB};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int rl   [2] = '{1, 5};      // issue period
   int pen  [2] = '{2, 3};      // squash cycles after a clean control op
   int cmax [2] = '{65535, 15}; // counter ceiling
   int phase[2];                // non-busy cycles since reset, modulo period
   int sq   [2];                // squash cycles still owed (0 = running)
   int sc   [2];
   int bc   [2];

   function automatic logic dep(input logic u, input logic [4:0] s, input logic [4:0] d);
      return u && (s != 5'd0) && (s == d);
   endfunction

   function automatic logic hazard();
      logic on_x, on_m;
      on_x = dep(urs, rs, xw) || dep(urt, rt, xw);
      on_m = dep(urs, rs, mw) || dep(urt, rt, mw);
      return (xwe && xmr && on_x) || ((jmp || br) && ((xwe && on_x) || (mmr && on_m)));
   endfunction

   function automatic logic [7:0] expect_out(input int k);
      if (rst)                  return 8'b0000_0000;
      if (busy)                 return 8'b1010_1001;
      if (hazard())             return 8'b1001_0000;
      if (sq[k] > 0)            return 8'b0100_0000;
      if (phase[k] % rl[k] != 0) return 8'b1100_0000;
      return 8'b0000_0000;
   endfunction

   task automatic model_reset(input int k);
      phase[k] = 0;
      sq[k]    = 0;
      sc[k]    = 0;
      bc[k]    = 0;
   endtask

   task automatic model_step(input int k, input logic [7:0] e);
      if (rst) begin
         model_reset(k);
      end else begin
         if (clr) sc[k] = 0; else if (e[7] && sc[k] < cmax[k]) sc[k]++;
         if (clr) bc[k] = 0; else if (e[4] && bc[k] < cmax[k]) bc[k]++;
         if (!busy) begin
            phase[k] = (phase[k] + 1) % rl[k];
            if (sq[k] > 0) sq[k]--;
            else if ((jmp || br) && !hazard() && pen[k] > 0) sq[k] = pen[k];
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: compare outputs mid-cycle, then advance the model on the edge.
   task automatic run_cycle();
      logic [7:0] ea, eb;
      #1;
      if (rst) begin
         model_reset(0);
         model_reset(1);
      end
      ea = expect_out(0);
      eb = expect_out(1);
      chk("strobes_a", {24'd0, out_a}, {24'd0, ea});
      chk("strobes_b", {24'd0, out_b}, {24'd0, eb});
      chk("stall_cnt_a",  {16'd0, if_a.STALL_COUNT_OUT},  sc[0]);
      chk("bubble_cnt_a", {16'd0, if_a.BUBBLE_COUNT_OUT}, bc[0]);
      chk("stall_cnt_b",  {28'd0, if_b.STALL_COUNT_OUT},  sc[1]);
      chk("bubble_cnt_b", {28'd0, if_b.BUBBLE_COUNT_OUT}, bc[1]);
      @(posedge clk);
      model_step(0, ea);
      model_step(1, eb);
      #1;
   endtask

   task automatic set_idle();
      jmp = 0; br = 0; urs = 0; urt = 0; xwe = 0; xmr = 0; mmr = 0; busy = 0; clr = 0;
      rs = 0; rt = 0; xw = 0; mw = 0;
   endtask

   task automatic set_rand();
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      xw   = 5'($urandom_range(0, 3));
      mw   = 5'($urandom_range(0, 3));
      urs  = ($urandom_range(0, 3) != 0);
      urt  = ($urandom_range(0, 3) != 0);
      xwe  = ($urandom_range(0, 1) != 0);
      xmr  = ($urandom_range(0, 4) < 2);
      mmr  = ($urandom_range(0, 9) < 3);
      jmp  = ($urandom_range(0, 9) == 0);
      br   = ($urandom_range(0, 9) == 0);
      busy = ($urandom_range(0, 9) == 0);
      clr  = ($urandom_range(0, 29) == 0);
      rst  = ($urandom_range(0, 199) == 0);
   endtask

   task automatic idle_cycles(input int n);
      set_idle();
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   initial begin
      set_idle();
      rst = 1'b1;
      model_reset(0);
      model_reset(1);
      run_cycle();
      run_cycle();
      rst = 1'b0;

      // idle ring pattern, then a 3-cycle memory stall shifting it
      idle_cycles(12);
      set_idle(); busy = 1;
      for (int i = 0; i < 3; i++) run_cycle();
      idle_cycles(6);

      // load-use on r5, then the same with r0
      set_idle(); xwe = 1; xmr = 1; xw = 5; rs = 5; urs = 1;
      run_cycle();
      idle_cycles(1);
      set_idle(); xwe = 1; xmr = 1; xw = 0; rs = 0; urs = 1;
      run_cycle();
      idle_cycles(1);

      // load feeding a branch: two bubbles, then the branch leaves ID
      set_idle(); br = 1; rt = 8; urt = 1; xw = 8; xwe = 1; xmr = 1;
      run_cycle();
      set_idle(); br = 1; rt = 8; urt = 1; mw = 8; mmr = 1;
      run_cycle();
      set_idle(); br = 1; rt = 8; urt = 1;
      run_cycle();
      idle_cycles(6);

      // jump with a memory stall in the middle of the squash
      set_idle(); jmp = 1;
      run_cycle();
      idle_cycles(1);
      set_idle(); busy = 1;
      run_cycle();
      idle_cycles(5);

      // long stall to saturate the narrow counters, then clear
      set_idle(); busy = 1;
      for (int i = 0; i < 20; i++) run_cycle();
      set_idle(); clr = 1;
      run_cycle();
      idle_cycles(2);

      // reset asserted in the middle of a squash
      set_idle(); jmp = 1;
      run_cycle();
      idle_cycles(1);
      rst = 1'b1;
      #1;
      chk("ring_in_reset_b", {27'd0, u_b.ring_q}, 32'd1);
      run_cycle();
      rst = 1'b0;
      idle_cycles(3);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         set_rand();
         run_cycle();
      end
      rst = 1'b0;
      idle_cycles(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
      $finish;
   end

endmodule
